transfer_handler: RTL and testbench
===================================

Name: transfer_handler

Overview:
AHB-Lite read-burst sequencer on the I-cache master interface. It accepts a single-cycle NONSEQ request (start address plus burst type) from the cache side. It then drives the full AHB address-phase sequence (trans_out, read_addr) for every beat of the burst, honouring hready wait states. It captures hrdata into read_data on each completed data phase.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
addr  in  32  request start address, sampled with htrans
hwrite  in  1  request direction, 1 = write
hrdata  in  32  slave read data
hready  in  1  slave ready; 0 = wait state
hwdata  in  32  write data; accepted, no internal use
hburst  in  3  burst type (burst_t)
htrans  in  2  request transfer type (trans_t)
read_addr  out  32  HADDR driven to slave
read_data  out  32  last captured read beat
trans_out  out  2  HTRANS driven to slave

Behaviour:
- Reset (asynchronous, rstn=0): read_addr=0, read_data=0, trans_out=IDLE, FSM in S_IDLE, beat counters cleared. Reset mid-burst aborts the burst immediately.
- FSM states: S_IDLE, S_ADDR, S_LAST_DATA.
- S_IDLE:
  - At a posedge with htrans==NONSEQ, latch: addr with [1:0] forced to 0, hburst, hwrite. Load beats = SINGLE:1, INCR:1, WRAP4/INCR4:4, WRAP8/INCR8:8, WRAP16/INCR16:16.
  - Same edge: trans_out<=NONSEQ, read_addr<=latched address, go to S_ADDR.
  - Request latency: 1 cycle. htrans IDLE/BUSY/SEQ in S_IDLE are ignored.
- S_ADDR: the beat is accepted at a posedge with hready=1.
  - Remaining beats: read_addr<=next address, trans_out<=SEQ.
  - Last beat accepted: trans_out<=IDLE, read_addr holds, go to S_LAST_DATA.
  - hready=0: read_addr and trans_out hold.
- Data phase: the cycle after each accepted beat.
  - For reads, read_data<=hrdata at the posedge ending that data phase with hready=1.
  - Writes never update read_data.
  - read_data holds otherwise.
- S_LAST_DATA: wait for the final data phase to complete (hready=1), then return to S_IDLE. Back-to-back requests therefore have at least one IDLE cycle between bursts.
- A new NONSEQ on htrans outside S_IDLE is dropped, not queued.
- Next address (beat size fixed at 4 bytes):
  - INCRx: a+4 modulo 2^32, so 0xFFFF_FFFC -> 0x0000_0000.
  - WRAPx with block B = 16/32/64 bytes: (a & ~(B-1)) | ((a+4) & (B-1)).
- Write requests sequence addresses identically to reads.
- hburst values are all legal; no error response is generated.

Decomposition:
- Shared package interface_pkg:
  - trans_t enum (2 b): IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - burst_t enum (3 b): SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - BEAT_BYTES=4.
- One natural sub-module, burst_addr_gen: combinational function of current address and burst type, returning next address and beat count.

Test Plan:
- Reset: rstn=0 with random inputs -> read_addr=0, read_data=0, trans_out=IDLE; after release with htrans=IDLE, outputs stay unchanged.
- SINGLE read, addr=0x1000, hready=1 -> next cycle trans_out=NONSEQ, read_addr=0x1000; following cycle trans_out=IDLE; read_data=hrdata (e.g. 0xDEADBEEF) captured one cycle later.
- WRAP4 read, addr=0x0000_0038, hready=1 -> read_addr sequence 0x38, 0x3C, 0x30, 0x34; trans_out NONSEQ, SEQ, SEQ, SEQ, then IDLE; four read_data updates.
- INCR4 read, addr=0xFFFF_FFF8, hready toggling (low 1 cycle of every 2) -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4, each held through wait cycles; read_data updates only on hready=1 data-phase edges.
- WRAP16 write, addr=0x4, hwrite=1 -> 16 beats wrapping within 0x00–0x3C; read_data unchanged throughout.
- Request during burst: NONSEQ addr=0x2000 issued while a WRAP8 burst is in progress -> ignored, no extra beats generated; rstn=0 mid-burst -> outputs zero/IDLE asynchronously.

Source files
------------

// File: rtl/transfer_handler_pkg.sv
// Shared types and constants for the AHB-Lite read-burst sequencer.
// Covers transfer and burst encodings, FSM states and the beat-count lookup.
package transfer_handler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR      = 2'd1,
    S_LAST_DATA = 2'd2
  } state_t;

  localparam int BEAT_BYTES = 4;
  localparam int BEATS_W    = 5;

  // Undefined-length INCR is issued as a single beat.
  function automatic logic [BEATS_W-1:0] burst_beats(input burst_t b);
    case (b)
      WRAP4, INCR4:   burst_beats = BEATS_W'(4);
      WRAP8, INCR8:   burst_beats = BEATS_W'(8);
      WRAP16, INCR16: burst_beats = BEATS_W'(16);
      default:        burst_beats = BEATS_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/transfer_handler_if.sv
// Cache-side request / AHB slave-side signal bundle for transfer_handler.
// The slave modport is the sequencer's view; fsm_state is a debug tap.
interface transfer_handler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import transfer_handler_pkg::*;

  // Request is a single-cycle NONSEQ on htrans; bus beats complete on hready=1.
  logic [ADDR_W-1:0] addr;
  logic              hwrite;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic [DATA_W-1:0] hwdata;
  logic [2:0]        hburst;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic [1:0]        trans_out;
  state_t            fsm_state;

  modport slave (
    input  addr, hwrite, hrdata, hready, hwdata, hburst, htrans,
    output read_addr, read_data, trans_out, fsm_state
  );

  modport master (
    output addr, hwrite, hrdata, hready, hwdata, hburst, htrans,
    input  read_addr, read_data, trans_out, fsm_state
  );

endinterface

// File: rtl/transfer_handler_burst_addr_gen.sv
// Next-beat address and burst length for fixed 4-byte beats.
// Wrapping bursts stay inside their 16/32/64-byte aligned block.
module burst_addr_gen
  import transfer_handler_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  cur_addr,
  input  burst_t             burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic [BEATS_W-1:0] beats
);

  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    inc_addr = cur_addr + ADDR_W'(BEAT_BYTES);
    case (burst)
      WRAP4:   wrap_mask = ADDR_W'(15);
      WRAP8:   wrap_mask = ADDR_W'(31);
      WRAP16:  wrap_mask = ADDR_W'(63);
      default: wrap_mask = '0;
    endcase
    // An all-zero mask means a plain incrementing burst.
    if (wrap_mask == '0) begin
      next_addr = inc_addr;
    end else begin
      next_addr = (cur_addr & ~wrap_mask) | (inc_addr & wrap_mask);
    end
    beats = burst_beats(burst);
  end

endmodule

// File: rtl/transfer_handler.sv
// AHB-Lite burst sequencer: turns one NONSEQ request into the full address-phase
// sequence and captures read data at the end of every completed data phase.
module transfer_handler
  import transfer_handler_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rstn,
  transfer_handler_if.slave bus
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  trans_t               trans_q, trans_d;
  logic [DATA_W-1:0]    data_q, data_d;
  burst_t               burst_q, burst_d;
  logic                 write_q, write_d;
  logic [BEATS_W-1:0]   beats_q, beats_d;
  logic                 data_pend_q, data_pend_d;

  burst_t               gen_burst;
  logic [ADDR_W-1:0]    gen_next;
  logic [BEATS_W-1:0]   gen_beats;
  logic                 hwdata_unused;

  assign hwdata_unused = ^bus.hwdata;

  // Beat count is only needed in S_IDLE (from the live request); the next
  // address is only needed afterwards (from the latched burst type).
  assign gen_burst = (state_q == S_IDLE) ? burst_t'(bus.hburst) : burst_q;

  burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .cur_addr  (addr_q),
    .burst     (gen_burst),
    .next_addr (gen_next),
    .beats     (gen_beats)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trans_d     = trans_q;
    data_d      = data_q;
    burst_d     = burst_q;
    write_d     = write_q;
    beats_d     = beats_q;
    data_pend_d = data_pend_q;

    // hready ends the pending data phase and the current address phase together.
    if (data_pend_q && bus.hready) begin
      data_pend_d = 1'b0;
      if (!write_q) data_d = bus.hrdata;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.htrans == NONSEQ) begin
          addr_d  = bus.addr & ~ADDR_W'(3);
          burst_d = burst_t'(bus.hburst);
          write_d = bus.hwrite;
          beats_d = gen_beats;
          trans_d = NONSEQ;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.hready) begin
          data_pend_d = 1'b1;
          if (beats_q == BEATS_W'(1)) begin
            trans_d = IDLE;
            state_d = S_LAST_DATA;
          end else begin
            addr_d  = gen_next;
            trans_d = SEQ;
            beats_d = beats_q - BEATS_W'(1);
          end
        end
      end
      S_LAST_DATA: begin
        if (bus.hready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      trans_q     <= IDLE;
      data_q      <= '0;
      burst_q     <= SINGLE;
      write_q     <= 1'b0;
      beats_q     <= '0;
      data_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trans_q     <= trans_d;
      data_q      <= data_d;
      burst_q     <= burst_d;
      write_q     <= write_d;
      beats_q     <= beats_d;
      data_pend_q <= data_pend_d;
    end
  end

  assign bus.read_addr = addr_q;
  assign bus.read_data = data_q;
  assign bus.trans_out = trans_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_transfer_handler.sv
// Directed plus randomized bench for transfer_handler, checked cycle by cycle
// against a beat-level AHB reference model built from address lists.
module tb_transfer_handler;
  import transfer_handler_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  transfer_handler_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  transfer_handler #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: whole-burst address list plus beat progress.
  logic [31:0] exp_q[$];
  bit          m_busy, m_in_addr, m_dp, m_write;
  int          m_idx;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_trans;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".read_addr"}, bus.read_addr, m_addr);
    check({tag, ".trans_out"}, {30'd0, bus.trans_out}, {30'd0, m_trans});
    check({tag, ".read_data"}, bus.read_data, m_data);
  endtask

  function automatic void model_reset();
    m_busy = 0; m_in_addr = 0; m_dp = 0; m_write = 0; m_idx = 0;
    m_addr = '0; m_data = '0; m_trans = IDLE;
    exp_q.delete();
  endfunction

  function automatic int beats_for(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  // Beat i lives at offset (start + 4i) mod block inside the aligned block.
  function automatic void build_addrs(input logic [31:0] a, input logic [2:0] b);
    logic [31:0] start, base, blk;
    int n;
    n = beats_for(b);
    start = a & 32'hFFFF_FFFC;
    blk = 32'(4 * n);
    base = start - (start % blk);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (b == 3'd2 || b == 3'd4 || b == 3'd6)
        exp_q.push_back(base + ((start - base + 32'(4 * i)) % blk));
      else
        exp_q.push_back(start + 32'(4 * i));
    end
  endfunction

  task automatic step(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                      input logic w, input logic r, input logic [31:0] d, input string tag);
    bus.htrans = t; bus.addr = a; bus.hburst = b; bus.hwrite = w;
    bus.hready = r; bus.hrdata = d; bus.hwdata = $urandom;
    if (m_dp && r) begin
      m_dp = 0;
      if (!m_write) m_data = d;
    end
    if (!m_busy) begin
      if (t == NONSEQ) begin
        build_addrs(a, b);
        m_write = w; m_idx = 0; m_addr = exp_q[0]; m_trans = NONSEQ;
        m_busy = 1; m_in_addr = 1;
      end
    end else if (m_in_addr) begin
      if (r) begin
        m_dp = 1;
        if (m_idx == exp_q.size() - 1) begin
          m_trans = IDLE; m_in_addr = 0;
        end else begin
          m_idx++; m_addr = exp_q[m_idx]; m_trans = SEQ;
        end
      end
    end else if (r) begin
      m_busy = 0;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  function automatic logic [1:0] idle_noise();
    logic [1:0] t;
    t = 2'($urandom_range(0, 2));
    return (t == 2'd2) ? 2'd3 : t;
  endfunction

  // mode 0: always ready, 1: ready every other cycle, 2: random ready and
  // random htrans noise, 3: always ready with a NONSEQ to 0x2000 every cycle.
  task automatic run_burst(input logic [31:0] a, input logic [2:0] b, input logic w,
                           input int mode, input string tag);
    logic rdy;
    logic [1:0] t;
    int guard;
    step(NONSEQ, a, b, w, 1'($urandom_range(0, 1)), $urandom, tag);
    rdy = 1'b1;
    guard = 0;
    while (m_busy && guard < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      t = (mode == 2) ? 2'($urandom_range(0, 3)) : ((mode == 3) ? NONSEQ : IDLE);
      step(t, (mode == 3) ? 32'h2000 : $urandom, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), rdy, $urandom, tag);
      guard++;
    end
    n_tests++;
    if (m_busy) begin
      n_fail++;
      $display("FAIL %s burst_timeout observed=busy required=idle", tag);
    end
    step(IDLE, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), $urandom, {tag, ".after"});
  endtask

  initial begin
    model_reset();
    rstn = 1'b0;
    bus.htrans = 2'($urandom_range(0, 3)); bus.addr = $urandom; bus.hburst = 3'($urandom_range(0, 7));
    bus.hwrite = 1'($urandom_range(0, 1)); bus.hready = 1'($urandom_range(0, 1));
    bus.hrdata = $urandom; bus.hwdata = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
      check_outputs("reset");
      bus.htrans = 2'($urandom_range(0, 3)); bus.addr = $urandom; bus.hrdata = $urandom;
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++)
      step(idle_noise(), $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, "idle_noise");

    run_burst(32'h0000_1000, 3'd0, 1'b0, 0, "single_rd");
    run_burst(32'h0000_0038, 3'd2, 1'b0, 0, "wrap4_rd");
    run_burst(32'hFFFF_FFF8, 3'd3, 1'b0, 1, "incr4_wait");
    run_burst(32'h0000_0004, 3'd6, 1'b1, 0, "wrap16_wr");
    run_burst(32'h0000_0104, 3'd4, 1'b0, 3, "wrap8_intrude");

    // Reset in the middle of a WRAP8 burst must clear outputs without a clock.
    step(NONSEQ, 32'h0000_0210, 3'd4, 1'b0, 1'b1, $urandom, "rst_mid");
    for (int i = 0; i < 3; i++) step(IDLE, '0, 3'd0, 1'b0, 1'b1, $urandom, "rst_mid");
    rstn = 1'b0;
    #2;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk); #1;
    check_outputs("rst_held");
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(IDLE, $urandom, 3'd0, 1'b0, 1'b1, $urandom, "rst_after");

    for (int i = 0; i < 30; i++)
      run_burst($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
